// File: rtl/run_sequencer_if.sv
// Run-control bundle between the host/bench and the run sequencer.
// The host drives req and the core's current PC; the sequencer answers with
// core control (core_rst/core_en) and run status (busy/done/timeout/cycle_cnt).
interface run_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          req;
  logic [D-1:0]  prog_ctr;
  logic          core_rst;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  // host / bench side
  modport master (
    output req, prog_ctr,
    input  core_rst, core_en, busy, done, timeout, cycle_cnt
  );

  // sequencer side
  modport slave (
    input  req, prog_ctr,
    output core_rst, core_en, busy, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: on a req rising edge clear the core, run it until prog_ctr hits HALT_PC
// or the cycle budget runs out, drain one cycle, then report done/timeout/cycle_cnt.
// Latency: rise at edge N -> CLEAR after N, RUN after N+CLR_CYCLES; halt at M -> done after M+1.
// Backpressure: done is held until req drops; req changes outside IDLE/DONE are ignored.
module run_sequencer #(
  parameter int D          = 12,
  parameter int HALT_PC    = 128,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 4096,
  parameter int CLR_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  run_sequencer_if.slave seq
);

  localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0]   BUDGET   = CW'(MAX_CYCLES);
  localparam logic [D-1:0]    HALT_ADR = D'(HALT_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            req_q;
  logic            rise;
  logic            halt;
  logic            expire;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   cycle_cnt;
  logic            timeout;
  logic [CLRW-1:0] clr_cnt;

  assign rise    = seq.req & ~req_q;
  assign halt    = (seq.prog_ctr == HALT_ADR);
  assign cnt_inc = cycle_cnt + CW'(1);
  assign expire  = (cnt_inc == BUDGET);

  // req history for edge detection; cleared by reset so a high req after release is a rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req_q <= 1'b0;
    else        req_q <= seq.req;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic; halt takes priority over budget expiry
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (rise) state_nx = S_CLEAR;
      S_CLEAR: if (clr_cnt == CLR_LAST) state_nx = S_RUN;
      S_RUN:   if (halt || expire) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  if (!seq.req) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // clear-phase counter, RUN-cycle counter and timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt   <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            clr_cnt   <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt != CLR_LAST) clr_cnt <= clr_cnt + CLRW'(1);
        end
        S_RUN: begin
          // the exit edge is counted too, so cycle_cnt equals the core_en cycles of the run
          cycle_cnt <= cnt_inc;
          if (!halt && expire) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // outputs are pure decodes of registered state
  assign seq.core_rst  = (state == S_IDLE) || (state == S_CLEAR);
  assign seq.core_en   = (state == S_RUN);
  assign seq.busy      = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign seq.done      = (state == S_DONE);
  assign seq.timeout   = timeout;
  assign seq.cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances cover the default budget,
// a 300-cycle budget with a stuck PC, and a budget equal to the halt run length.
module tb_run_sequencer;

  logic clk;
  logic reset;
  logic [11:0] pc0;
  logic [11:0] pc2;
  logic [11:0] pc_fixed;
  int checks;
  int errors;

  run_sequencer_if #(.D(12), .CW(16)) if0 ();
  run_sequencer_if #(.D(12), .CW(16)) if1 ();
  run_sequencer_if #(.D(12), .CW(16)) if2 ();

  run_sequencer u_def (.clk(clk), .reset(reset), .seq(if0));
  run_sequencer #(.MAX_CYCLES(300)) u_bud (.clk(clk), .reset(reset), .seq(if1));
  run_sequencer #(.MAX_CYCLES(129)) u_col (.clk(clk), .reset(reset), .seq(if2));

  assign if0.prog_ctr = pc0;
  assign if1.prog_ctr = pc_fixed;
  assign if2.prog_ctr = pc2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC models: cleared by core_rst, advance once per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc0 <= '0;
      pc2 <= '0;
    end else begin
      if (if0.core_rst)     pc0 <= '0;
      else if (if0.core_en) pc0 <= pc0 + 12'd1;
      if (if2.core_rst)     pc2 <= '0;
      else if (if2.core_en) pc2 <= pc2 + 12'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int t;
    int t_halt;
    int t_done;
    int en_cnt;
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    if0.req  = 1'b0;
    if1.req  = 1'b0;
    if2.req  = 1'b0;
    pc_fixed = 12'd0;

    // 1: reset held, inputs toggling -> reset outputs throughout
    #2;
    for (int i = 0; i < 6; i++) begin
      if0.req  = i[0];
      if1.req  = ~i[0];
      pc_fixed = (i[1]) ? 12'd128 : 12'd7;
      tick();
      chk("rst_core_rst", if0.core_rst, 1);
      chk("rst_core_en", if0.core_en, 0);
      chk("rst_busy_done", {if0.busy, if0.done, if1.busy, if1.done}, 0);
      chk("rst_cycle_cnt", if1.cycle_cnt, 0);
    end
    if0.req  = 1'b0;
    if1.req  = 1'b0;
    pc_fixed = 12'd5;
    tick();
    reset = 1'b1;
    tick();
    chk("idle_after_release", {if0.core_rst, if0.core_en, if0.busy, if0.done}, 4'b1000);

    // 2: normal run on the default instance
    if0.req = 1'b1;
    tick();
    chk("clear1", {if0.core_rst, if0.core_en, if0.busy}, 3'b101);
    chk("clear1_cnt", if0.cycle_cnt, 0);
    tick();
    chk("clear2", {if0.core_rst, if0.core_en, if0.busy}, 3'b101);
    tick();
    chk("run1", {if0.core_rst, if0.core_en, if0.busy}, 3'b011);
    chk("run1_pc", pc0, 0);
    t = 0; t_halt = -1; t_done = -1; en_cnt = 0;
    while (t < 400) begin
      if (pc0 == 12'd128 && t_halt < 0) t_halt = t;
      if (t_halt >= 0 && t == t_halt + 1)
        chk("drain", {if0.core_rst, if0.core_en, if0.busy, if0.done}, 4'b0010);
      if (if0.core_en) en_cnt++;
      if (if0.done) begin
        t_done = t;
        break;
      end
      tick();
      t++;
    end
    chk("run_done", if0.done, 1);
    chk("run_done_lat", t_done - t_halt, 2);
    chk("run_en_cycles", en_cnt, 129);
    chk("run_cycle_cnt", if0.cycle_cnt, 129);
    chk("run_timeout", if0.timeout, 0);
    chk("done_outputs", {if0.core_rst, if0.core_en, if0.busy}, 3'b000);

    // 6: handshake - done held while req high, restart only on a fresh rise
    tick(); tick(); tick();
    chk("hold_done", {if0.done, if0.busy}, 2'b10);
    chk("hold_cnt", if0.cycle_cnt, 129);
    if0.req = 1'b0;
    tick();
    chk("back_idle", {if0.done, if0.core_rst, if0.busy}, 3'b010);
    if0.req = 1'b1;
    tick();
    chk("restart_clear", {if0.busy, if0.core_rst}, 2'b11);
    chk("restart_cnt", if0.cycle_cnt, 0);
    for (int i = 0; i < 22; i++) tick();
    if0.req = 1'b0;
    tick();
    if0.req = 1'b1;
    tick();
    chk("glitch_run", {if0.busy, if0.core_en}, 2'b11);
    t = 0;
    while (t < 400 && !if0.done) begin
      tick();
      t++;
    end
    chk("glitch_done", if0.done, 1);
    chk("glitch_cnt", if0.cycle_cnt, 129);
    chk("glitch_timeout", if0.timeout, 0);

    // 3: budget expiry with the PC stuck
    if1.req = 1'b1;
    t = 0; en_cnt = 0;
    while (t < 1000 && !if1.done) begin
      if (if1.core_en) en_cnt++;
      tick();
      t++;
    end
    chk("bud_done", if1.done, 1);
    chk("bud_en_cycles", en_cnt, 300);
    chk("bud_timeout", if1.timeout, 1);
    chk("bud_cnt", if1.cycle_cnt, 300);

    // 4: halt and budget on the same edge -> halt wins
    if2.req = 1'b1;
    t = 0;
    while (t < 1000 && !if2.done) begin
      tick();
      t++;
    end
    chk("col_done", if2.done, 1);
    chk("col_timeout", if2.timeout, 0);
    chk("col_cnt", if2.cycle_cnt, 129);

    // 5: reset mid-run, then automatic restart with req still high
    if1.req = 1'b0;
    if2.req = 1'b0;
    if0.req = 1'b0;
    tick();
    if0.req = 1'b1;
    tick(); tick(); tick();
    chk("mid_run_start", if0.core_en, 1);
    for (int i = 0; i < 49; i++) tick();
    chk("mid_run_cnt", if0.cycle_cnt, 49);
    reset = 1'b0;
    #1;
    chk("async_core_rst", if0.core_rst, 1);
    chk("async_core_en", if0.core_en, 0);
    chk("async_cnt", if0.cycle_cnt, 0);
    chk("async_busy", if0.busy, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rerun_clear", {if0.busy, if0.core_rst}, 2'b11);
    t = 0;
    while (t < 400 && !if0.done) begin
      tick();
      t++;
    end
    chk("rerun_done", if0.done, 1);
    chk("rerun_cnt", if0.cycle_cnt, 129);
    chk("rerun_timeout", if0.timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
